// File: rtl/cd_rx_ring_pkg.sv
// cd_rx_ring_pkg
//  Shared defaults for the RX frame ring buffer and a helper for sizing the
//  pending-frame counter. Imported by cd_rx_ring and cd_ram_sdp.
package cd_rx_ring_pkg;

    localparam int CD_PAGES_DEF  = 4;   // page count, power of 2, >= 2
    localparam int CD_ADDR_W_DEF = 8;   // byte address width per page
    localparam int CD_LOST_W_DEF = 8;   // lost-frame counter width

    // Width able to hold 0..PAGES-1 frames plus one spare bit so that
    // pending-1 arithmetic never aliases.
    function automatic int cd_pend_w(input int pages);
        return $clog2(pages) + 1;
    endfunction

endpackage

// File: rtl/cd_ram_sdp.sv
// cd_ram_sdp
//  Simple dual-port RAM, (2**ADDR_W) x DATA_W. One write port, one read port
//  with read enable and a registered output (1-cycle latency). The output
//  register clears on reset and holds its value while re is low.
// Ports
//  clk, reset_n       clock, synchronous active-low reset (output reg only)
//  we, waddr, wdata   write port
//  re, raddr, rdata   read port, rdata valid one cycle after re
module cd_ram_sdp
    import cd_rx_ring_pkg::*;
#(
    parameter int ADDR_W = CD_ADDR_W_DEF + $clog2(CD_PAGES_DEF),
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rdata_reg;

    // Array contents are never reset so this maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rdata_reg <= '0;
        end else if (re) begin
            rdata_reg <= mem[raddr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/cd_rx_ring.sv
// cd_rx_ring
//  N-page RX frame ring buffer between the RX byte assembler (writer) and the
//  CSR block (reader). The writer fills page wp; switch commits it as a frame.
//  Up to PAGES-1 committed frames wait for the CPU, oldest at page rp.
//  Per-page length/error metadata, pending count, saturating lost counter.
// Ports
//  clk, reset_n                        clock, synchronous active-low reset
//  wr_byte, wr_addr, wr_en             byte write into page wp
//  wr_len, wr_err, switch              frame commit; switch_fail if ring full
//  rd_addr, rd_en, rd_byte             registered byte read from page rp
//  rd_len, rd_err                      metadata of page rp (valid if pending>0)
//  rd_done, rd_done_all                release oldest / discard all unread
//  unread, pending, lost_cnt           status
module cd_rx_ring
    import cd_rx_ring_pkg::*;
#(
    parameter int PAGES  = CD_PAGES_DEF,
    parameter int ADDR_W = CD_ADDR_W_DEF,
    parameter int LOST_W = CD_LOST_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [7:0]               wr_byte,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_len,
    input  logic                     wr_err,
    input  logic                     switch,
    output logic                     switch_fail,
    input  logic [ADDR_W-1:0]        rd_addr,
    input  logic                     rd_en,
    output logic [7:0]               rd_byte,
    output logic [ADDR_W-1:0]        rd_len,
    output logic                     rd_err,
    input  logic                     rd_done,
    input  logic                     rd_done_all,
    output logic                     unread,
    output logic [$clog2(PAGES):0]   pending,
    output logic [LOST_W-1:0]        lost_cnt
);

    localparam int PTR_W  = $clog2(PAGES);
    localparam int PEND_W = cd_pend_w(PAGES);

    logic [PTR_W-1:0]  wp_reg, rp_reg;
    logic [PEND_W-1:0] pending_reg;
    logic [LOST_W-1:0] lost_cnt_reg;
    logic              switch_fail_reg;

    logic              rel_ok;
    logic              commit_ok;
    logic [PEND_W-1:0] pending_eff;

    // Release is accounted before the commit decision, so a full ring that
    // releases a page in the same cycle still accepts the new frame.
    assign rel_ok      = rd_done && (pending_reg != '0);
    assign pending_eff = pending_reg - PEND_W'(rel_ok);
    assign commit_ok   = switch && (pending_eff < PEND_W'(PAGES - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wp_reg          <= '0;
            rp_reg          <= '0;
            pending_reg     <= '0;
            lost_cnt_reg    <= '0;
            switch_fail_reg <= 1'b0;
        end else if (rd_done_all) begin
            // Discard everything; a concurrent switch is dropped silently.
            rp_reg          <= wp_reg;
            pending_reg     <= '0;
            switch_fail_reg <= 1'b0;
        end else begin
            rp_reg          <= rp_reg + PTR_W'(rel_ok);
            wp_reg          <= wp_reg + PTR_W'(commit_ok);
            pending_reg     <= pending_eff + PEND_W'(commit_ok);
            switch_fail_reg <= switch && !commit_ok;
            if (switch && !commit_ok && (lost_cnt_reg != '1)) begin
                lost_cnt_reg <= lost_cnt_reg + LOST_W'(1);
            end
        end
    end

    // Per-page metadata {len, err}; written only on an accepted commit.
    logic [ADDR_W:0] meta_word [PAGES];

    generate
        for (genvar gi = 0; gi < PAGES; gi++) begin : g_meta
            logic [ADDR_W:0] meta_reg;
            always_ff @(posedge clk) begin
                if (reset_n && !rd_done_all && commit_ok && (wp_reg == PTR_W'(gi))) begin
                    meta_reg <= {wr_len, wr_err};
                end
            end
            assign meta_word[gi] = meta_reg;
        end
    endgenerate

    assign rd_len = meta_word[rp_reg][ADDR_W:1];
    assign rd_err = meta_word[rp_reg][0];

    cd_ram_sdp #(
        .ADDR_W (PTR_W + ADDR_W),
        .DATA_W (8)
    ) u_ram (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (wr_en),
        .waddr   ({wp_reg, wr_addr}),
        .wdata   (wr_byte),
        .re      (rd_en),
        .raddr   ({rp_reg, rd_addr}),
        .rdata   (rd_byte)
    );

    assign switch_fail = switch_fail_reg;
    assign pending     = pending_reg;
    assign unread      = (pending_reg != '0);
    assign lost_cnt    = lost_cnt_reg;

endmodule

// File: tb/tb_cd_rx_ring.sv
// tb_cd_rx_ring
//  Self-checking bench for cd_rx_ring: directed scenarios followed by random
//  traffic, all checked against a frame-queue reference model.
module tb_cd_rx_ring;

    localparam int PAGES  = 4;
    localparam int ADDR_W = 8;
    localparam int LOST_W = 2;
    localparam int LMAX   = 3;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [7:0]        wr_byte;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_len;
    logic              wr_err;
    logic              switch;
    logic              switch_fail;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_en;
    logic [7:0]        rd_byte;
    logic [ADDR_W-1:0] rd_len;
    logic              rd_err;
    logic              rd_done;
    logic              rd_done_all;
    logic              unread;
    logic [2:0]        pending;
    logic [LOST_W-1:0] lost_cnt;

    cd_rx_ring #(.PAGES(PAGES), .ADDR_W(ADDR_W), .LOST_W(LOST_W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr_byte     (wr_byte),
        .wr_addr     (wr_addr),
        .wr_en       (wr_en),
        .wr_len      (wr_len),
        .wr_err      (wr_err),
        .switch      (switch),
        .switch_fail (switch_fail),
        .rd_addr     (rd_addr),
        .rd_en       (rd_en),
        .rd_byte     (rd_byte),
        .rd_len      (rd_len),
        .rd_err      (rd_err),
        .rd_done     (rd_done),
        .rd_done_all (rd_done_all),
        .unread      (unread),
        .pending     (pending),
        .lost_cnt    (lost_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        int page;
        int len;
        bit err;
    } frame_t;

    frame_t     q[$];
    int         m_wp;
    int         m_lost;
    bit         m_fail;
    logic [7:0] m_mem   [PAGES][2**ADDR_W];
    bit         m_valid [PAGES][2**ADDR_W];
    logic [7:0] exp_rd;
    bit         rd_known;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int rp_model();
        return (q.size() > 0) ? q[0].page : m_wp;
    endfunction

    task automatic clear_inputs();
        wr_en = 0; switch = 0; rd_en = 0; rd_done = 0; rd_done_all = 0;
    endtask

    // One clock: advance the model from the current inputs, take the edge,
    // then compare every observable output.
    task automatic tick();
        int pg;
        if (!reset_n) begin
            q.delete();
            m_wp = 0; m_lost = 0; m_fail = 0;
            exp_rd = 8'h00; rd_known = 1;
        end else begin
            if (rd_en) begin
                pg = rp_model();
                // a same-cycle read and write of one location is left unchecked
                if (m_valid[pg][rd_addr] && !(wr_en && pg == m_wp && wr_addr == rd_addr)) begin
                    exp_rd = m_mem[pg][rd_addr];
                    rd_known = 1;
                end else begin
                    rd_known = 0;
                end
            end
            if (wr_en) begin
                m_mem[m_wp][wr_addr] = wr_byte;
                m_valid[m_wp][wr_addr] = 1;
            end
            if (rd_done_all) begin
                q.delete();
                m_fail = 0;
            end else begin
                if (rd_done && q.size() > 0) void'(q.pop_front());
                if (switch) begin
                    if (q.size() < PAGES - 1) begin
                        q.push_back('{m_wp, int'(wr_len), wr_err});
                        m_wp = (m_wp + 1) % PAGES;
                        m_fail = 0;
                    end else begin
                        m_fail = 1;
                        if (m_lost < LMAX) m_lost++;
                    end
                end else begin
                    m_fail = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("pending", 32'(pending), 32'(q.size()));
        chk("unread", 32'(unread), 32'(q.size() != 0));
        chk("switch_fail", 32'(switch_fail), 32'(m_fail));
        chk("lost_cnt", 32'(lost_cnt), 32'(m_lost));
        if (rd_known) chk("rd_byte", 32'(rd_byte), 32'(exp_rd));
        if (q.size() > 0) begin
            chk("rd_len", 32'(rd_len), 32'(q[0].len));
            chk("rd_err", 32'(rd_err), 32'(q[0].err));
        end
        clear_inputs();
    endtask

    task automatic wr(input int a, input int d);
        wr_en = 1; wr_addr = ADDR_W'(a); wr_byte = 8'(d);
        tick();
    endtask

    task automatic commit(input int len, input bit err);
        switch = 1; wr_len = ADDR_W'(len); wr_err = err;
        tick();
    endtask

    task automatic release_one();
        rd_done = 1;
        tick();
    endtask

    initial begin
        wr_byte = 0; wr_addr = 0; wr_len = 0; wr_err = 0; rd_addr = 0;
        clear_inputs();
        for (int p = 0; p < PAGES; p++)
            for (int a = 0; a < 2**ADDR_W; a++) m_valid[p][a] = 0;
        reset_n = 0;
        tick();
        tick();
        chk("rst_rd_byte", 32'(rd_byte), 32'h0);
        reset_n = 1;
        tick();

        // 1: five bytes into page 0, commit, read back offset 2
        for (int i = 0; i < 5; i++) wr(i, 8'hA0 + i);
        commit(5, 0);
        chk("t1_pending", 32'(pending), 32'd1);
        chk("t1_rd_len", 32'(rd_len), 32'd5);
        rd_en = 1; rd_addr = 2;
        tick();
        chk("t1_rd_byte", 32'(rd_byte), 32'hA2);
        release_one();

        // 2: three commits fill the ring, fourth is refused
        for (int f = 0; f < 3; f++) begin
            wr(0, 8'h10 + f);
            commit(10 + f, f[0]);
        end
        commit(20, 1);
        chk("t2_fail", 32'(switch_fail), 32'd1);
        chk("t2_lost", 32'(lost_cnt), 32'd1);
        chk("t2_pending", 32'(pending), 32'd3);
        tick();
        chk("t2_fail_pulse", 32'(switch_fail), 32'd0);
        wr(0, 8'h5A);                      // lands in the refused page

        // 3: full ring, switch plus rd_done in one cycle
        switch = 1; rd_done = 1; wr_len = 30; wr_err = 0;
        tick();
        chk("t3_fail", 32'(switch_fail), 32'd0);
        chk("t3_pending", 32'(pending), 32'd3);
        chk("t3_rd_len", 32'(rd_len), 32'd11);
        for (int i = 0; i < 3; i++) release_one();
        rd_en = 1; rd_addr = 0;            // empty ring: rp==wp
        tick();

        // 4: seven frames through the ring, lengths 1..7
        for (int f = 1; f <= 7; f++) begin
            wr(1, 8'h70 + f);
            commit(f, 0);
            chk("t4_rd_len", 32'(rd_len), 32'(f));
            rd_en = 1; rd_addr = 1;
            tick();
            chk("t4_rd_byte", 32'(rd_byte), 32'(8'h70 + f));
            release_one();
        end

        // 5: two pending, rd_done_all with switch
        commit(2, 0);
        commit(3, 1);
        rd_done_all = 1; switch = 1; wr_len = 9;
        tick();
        chk("t5_pending", 32'(pending), 32'd0);
        chk("t5_unread", 32'(unread), 32'd0);
        chk("t5_fail", 32'(switch_fail), 32'd0);
        chk("t5_lost", 32'(lost_cnt), 32'd1);
        release_one();
        chk("t5_ignored", 32'(pending), 32'd0);

        // 6: saturate the 2-bit lost counter, then reset
        for (int f = 0; f < 3; f++) commit(40 + f, 0);
        for (int k = 0; k < 5; k++) commit(50, 0);
        chk("t6_lost_sat", 32'(lost_cnt), 32'd3);
        reset_n = 0;
        tick();
        chk("t6_rst_pending", 32'(pending), 32'd0);
        chk("t6_rst_lost", 32'(lost_cnt), 32'd0);
        chk("t6_rst_fail", 32'(switch_fail), 32'd0);
        chk("t6_rst_unread", 32'(unread), 32'd0);
        chk("t6_rst_rd_byte", 32'(rd_byte), 32'd0);
        reset_n = 1;
        tick();

        // random traffic
        for (int n = 0; n < 800; n++) begin
            wr_en       = ($urandom_range(0, 1) == 1);
            wr_addr     = ADDR_W'($urandom_range(0, 7));
            wr_byte     = 8'($urandom);
            rd_en       = ($urandom_range(0, 1) == 1);
            rd_addr     = ADDR_W'($urandom_range(0, 7));
            switch      = ($urandom_range(0, 4) == 0);
            wr_len      = ADDR_W'($urandom);
            wr_err      = 1'($urandom);
            rd_done     = ($urandom_range(0, 3) == 0);
            rd_done_all = ($urandom_range(0, 40) == 0);
            reset_n     = ($urandom_range(0, 200) != 0);
            tick();
            reset_n = 1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
